// File: rtl/adc_link_pkg.sv
// Shared definitions for the single-wire ADC link (receiver and slave serializer).
package adc_link_pkg;

  localparam int LINK_DATA_W       = 16;
  localparam int LINK_PAYLOAD_BITS = 18;  // channel + data + parity
  localparam int LINK_FRAME_BITS   = 20;  // start + payload + stop

  localparam logic CH_LOWER = 1'b0;
  localparam logic CH_UPPER = 1'b1;

  localparam logic LINK_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    SHIFT,
    STOP,
    RECOVER
  } rx_state_e;

  // Even-parity bit that makes ones(channel, data, parity) even.
  function automatic logic link_parity(input logic ch, input logic [LINK_DATA_W-1:0] data);
    return ^{ch, data};
  endfunction

endpackage

// File: rtl/link_input_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle level
// so a reset never looks like a start bit.
module link_input_sync
  import adc_link_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic meta_q;

  // Metastability chain, both stages forced to idle on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q   <= LINK_IDLE_LEVEL;
      sync_out <= LINK_IDLE_LEVEL;
    end else begin
      meta_q   <= async_in;
      sync_out <= meta_q;
    end
  end

endmodule

// File: rtl/adc_stream_receiver.sv
// Receiver for the slave FPGA's framed ADC stream: recovers 16-bit words with
// their channel tag, checks parity and stop bit, counts link errors.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | line high, waiting for a falling edge
// START   | half-bit wait, confirm start bit is still low at mid-bit
// SHIFT   | sample 18 payload bits (channel, data MSB first, parity)
// STOP    | sample stop bit, issue valid / parity / frame strobe
// RECOVER | stop bit was low; wait for the line to return high
module adc_stream_receiver
  import adc_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int ERR_CNT_W    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   serial_in,
  output logic [LINK_DATA_W-1:0] rx_data,
  output logic                   rx_channel,
  output logic                   rx_valid,
  output logic                   parity_error,
  output logic                   frame_error,
  output logic [ERR_CNT_W-1:0]   error_count,
  output logic                   busy
);

  localparam int               TMR_W     = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [TMR_W-1:0] TMR_FULL  = TMR_W'(CLKS_PER_BIT);
  localparam logic [TMR_W-1:0] TMR_HALF  = TMR_W'(CLKS_PER_BIT / 2);
  localparam logic [4:0]       LAST_BIT  = 5'(LINK_PAYLOAD_BITS - 1);

  if ((CLKS_PER_BIT < 4) || ((CLKS_PER_BIT % 2) != 0)) begin : g_bad_clks_per_bit
    $error("adc_stream_receiver: CLKS_PER_BIT must be even and >= 4");
  end

  logic s;

  link_input_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (serial_in),
    .sync_out (s)
  );

  rx_state_e                    state_q, state_d;
  logic [TMR_W-1:0]             timer_q, timer_d;
  logic [4:0]                   bitcnt_q, bitcnt_d;
  logic [LINK_PAYLOAD_BITS-1:0] shreg_q, shreg_d;
  logic [LINK_DATA_W-1:0]       data_d;
  logic                         ch_d;
  logic                         valid_d, perr_d, ferr_d;
  logic [ERR_CNT_W-1:0]         err_cnt_d;
  logic                         tick;
  logic                         parity_ok;

  assign tick      = (timer_q == TMR_W'(1));
  assign parity_ok = (link_parity(shreg_q[17], shreg_q[16:1]) == shreg_q[0]);
  assign busy      = (state_q != IDLE);

  // State, timing and output registers; reset abandons any partial frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      bitcnt_q     <= '0;
      shreg_q      <= '0;
      rx_data      <= '0;
      rx_channel   <= CH_LOWER;
      rx_valid     <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
      error_count  <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      bitcnt_q     <= bitcnt_d;
      shreg_q      <= shreg_d;
      rx_data      <= data_d;
      rx_channel   <= ch_d;
      rx_valid     <= valid_d;
      parity_error <= perr_d;
      frame_error  <= ferr_d;
      error_count  <= err_cnt_d;
    end
  end

  // Framing: next state, bit timer, shift register and strobe decisions.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bitcnt_d  = bitcnt_q;
    shreg_d   = shreg_q;
    data_d    = rx_data;
    ch_d      = rx_channel;
    valid_d   = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!s) begin
          state_d = START;
          timer_d = TMR_HALF;
        end
      end

      START: begin
        if (tick) begin
          if (!s) begin
            state_d  = SHIFT;
            timer_d  = TMR_FULL;
            bitcnt_d = '0;
          end else begin
            state_d = IDLE;  // glitch shorter than half a bit
          end
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end

      SHIFT: begin
        if (tick) begin
          shreg_d  = {shreg_q[LINK_PAYLOAD_BITS-2:0], s};
          timer_d  = TMR_FULL;
          bitcnt_d = bitcnt_q + 5'd1;
          if (bitcnt_q == LAST_BIT) begin
            state_d = STOP;
          end
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end

      STOP: begin
        if (tick) begin
          if (s) begin
            // Returning to IDLE right away lets a back-to-back start bit be caught.
            state_d = IDLE;
            if (parity_ok) begin
              valid_d = 1'b1;
              data_d  = shreg_q[16:1];
              ch_d    = shreg_q[17];
            end else begin
              perr_d = 1'b1;
            end
          end else begin
            ferr_d  = 1'b1;
            state_d = RECOVER;
          end
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end

      RECOVER: begin
        if (s) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    err_cnt_d = error_count;
    if ((perr_d || ferr_d) && (error_count != {ERR_CNT_W{1'b1}})) begin
      err_cnt_d = error_count + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_adc_stream_receiver.sv
// Bench for adc_stream_receiver: frame-level model of expected strobes, held
// word/channel, error count and busy window, compared every cycle.
module tb_adc_stream_receiver;
  import adc_link_pkg::*;

  localparam int CPB  = 4;
  localparam int HALF = CPB / 2;
  localparam int LAT  = 2 + HALF + 19 * CPB;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        serial_in = 1'b1;
  logic [15:0] rx_data;
  logic        rx_channel, rx_valid, parity_error, frame_error, busy;
  logic [7:0]  error_count;

  adc_stream_receiver #(.CLKS_PER_BIT(CPB), .ERR_CNT_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .serial_in    (serial_in),
    .rx_data      (rx_data),
    .rx_channel   (rx_channel),
    .rx_valid     (rx_valid),
    .parity_error (parity_error),
    .frame_error  (frame_error),
    .error_count  (error_count),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_q = 1'b1;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // kind: 0 = valid word, 1 = parity error, 2 = frame error
  typedef struct { int at; int kind; logic ch; logic [15:0] data; } ev_t;
  typedef struct { int lo; int hi; } span_t;
  typedef struct { int at; logic ch; logic [15:0] data; } got_t;

  ev_t   ev_q[$];
  span_t busy_q[$];
  got_t  got_q[$];
  int    n_pe = 0;
  int    n_fe = 0;

  logic [15:0] m_data = '0;
  logic        m_ch   = 1'b0;
  int          m_cnt  = 0;

  // Per-cycle comparison of every output against the frame-level model.
  always @(negedge clk) begin
    logic  e_v, e_p, e_f, e_busy;
    ev_t   e;
    got_t  g;
    e_v = 1'b0; e_p = 1'b0; e_f = 1'b0; e_busy = 1'b0;
    if (rst_q) begin
      ev_q.delete();
      busy_q.delete();
      m_data = '0;
      m_ch   = 1'b0;
      m_cnt  = 0;
    end else begin
      if (ev_q.size() > 0 && ev_q[0].at == cyc) begin
        e = ev_q.pop_front();
        if (e.kind == 0) begin
          e_v = 1'b1; m_data = e.data; m_ch = e.ch;
        end else begin
          if (e.kind == 1) e_p = 1'b1; else e_f = 1'b1;
          if (m_cnt < 255) m_cnt++;
        end
      end
      while (busy_q.size() > 0 && busy_q[0].hi < cyc) void'(busy_q.pop_front());
      e_busy = (busy_q.size() > 0) && (cyc >= busy_q[0].lo);
      if (rx_valid === 1'b1) begin
        g.at = cyc; g.ch = rx_channel; g.data = rx_data;
        got_q.push_back(g);
      end
      if (parity_error === 1'b1) n_pe++;
      if (frame_error === 1'b1) n_fe++;
    end
    check("outputs{valid,perr,ferr,busy,ch,data,cnt}",
          {rx_valid, parity_error, frame_error, busy, rx_channel, rx_data, error_count},
          {e_v, e_p, e_f, e_busy, m_ch, m_data, 8'(m_cnt)});
  end

  task automatic idle(input int n);
    if (n > 0) begin
      serial_in = 1'b1;
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b);
    serial_in = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic ch, input logic [15:0] d, input logic par, input logic stp);
    int    c;
    ev_t   e;
    span_t sp;
    c      = cyc;
    e.at   = c + 1 + LAT;
    e.ch   = ch;
    e.data = d;
    if (!stp)                 e.kind = 2;
    else if (par != ^{ch, d}) e.kind = 1;
    else                      e.kind = 0;
    ev_q.push_back(e);
    if (stp) begin
      sp.lo = c + 3; sp.hi = c + LAT;
      busy_q.push_back(sp);
    end
    drive_bit(1'b0);
    drive_bit(ch);
    for (int i = 15; i >= 0; i--) drive_bit(d[i]);
    drive_bit(par);
    drive_bit(stp);
  endtask

  task automatic clear_logs();
    got_q.delete();
    n_pe = 0;
    n_fe = 0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int    c0;
    span_t sp;
    logic  ch;
    logic [15:0] d;
    logic  par;

    reset = 1'b1;
    serial_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_state", {rx_valid, parity_error, frame_error, busy, rx_channel, rx_data, error_count}, 64'd0);
    @(posedge clk); #1;
    idle(5);

    // 1: single lower frame
    clear_logs();
    c0 = cyc;
    send_frame(1'b0, 16'hA5A5, 1'b0, 1'b1);
    idle(4);
    check("t1_valid_count", got_q.size(), 1);
    if (got_q.size() >= 1) begin
      check("t1_latency", got_q[0].at - (c0 + 1), 80);
      check("t1_data", got_q[0].data, 16'hA5A5);
      check("t1_channel", got_q[0].ch, 1'b0);
    end
    check("t1_err_count", error_count, 8'd0);

    // 2: back-to-back, no idle gap
    clear_logs();
    send_frame(1'b1, 16'h0001, 1'b0, 1'b1);
    send_frame(1'b0, 16'hFFFF, 1'b0, 1'b1);
    idle(4);
    check("t2_valid_count", got_q.size(), 2);
    if (got_q.size() >= 2) begin
      check("t2_spacing", got_q[1].at - got_q[0].at, 80);
      check("t2_ch0", got_q[0].ch, 1'b1);
      check("t2_data0", got_q[0].data, 16'h0001);
      check("t2_ch1", got_q[1].ch, 1'b0);
      check("t2_data1", got_q[1].data, 16'hFFFF);
    end

    // 3: wrong parity
    clear_logs();
    send_frame(1'b1, 16'h1234, 1'b1, 1'b1);
    idle(4);
    check("t3_parity_strobes", n_pe, 1);
    check("t3_no_valid", got_q.size(), 0);
    check("t3_data_held", rx_data, 16'hFFFF);
    check("t3_err_count", error_count, 8'd1);

    // 4: stop bit low, line held low, then recovery
    clear_logs();
    c0 = cyc;
    sp.lo = c0 + 3; sp.hi = c0 + 20 * CPB + 100 + 2;
    busy_q.push_back(sp);
    send_frame(1'b0, 16'h00FF, 1'b0, 1'b0);
    serial_in = 1'b0;
    repeat (50) @(posedge clk);
    @(negedge clk);
    check("t4_busy_in_recover", busy, 1'b1);
    repeat (50) @(posedge clk);
    #1;
    serial_in = 1'b1;
    check("t4_frame_strobes", n_fe, 1);
    check("t4_no_other_strobes", got_q.size() + n_pe, 0);
    idle(8);
    check("t4_idle_after_recover", busy, 1'b0);
    send_frame(1'b1, 16'hBEEF, 1'b0, 1'b1);
    idle(4);
    check("t4_valid_count", got_q.size(), 1);
    if (got_q.size() >= 1) check("t4_data", got_q[0].data, 16'hBEEF);
    check("t4_err_count", error_count, 8'd2);

    // random frames, mostly good parity, random gaps including none
    for (int k = 0; k < 40; k++) begin
      ch  = 1'($urandom_range(0, 1));
      d   = 16'($urandom_range(0, 65535));
      par = ^{ch, d};
      if ($urandom_range(0, 3) == 0) par = ~par;
      send_frame(ch, d, par, 1'b1);
      idle($urandom_range(0, 6));
    end
    idle(4);

    // 5: short glitch, then saturation
    clear_logs();
    c0 = cyc;
    sp.lo = c0 + 3; sp.hi = c0 + 2 + HALF;
    busy_q.push_back(sp);
    serial_in = 1'b0;
    @(posedge clk); #1;
    serial_in = 1'b1;
    idle(10);
    check("t5_glitch_no_strobes", got_q.size() + n_pe + n_fe, 0);
    check("t5_glitch_idle", busy, 1'b0);
    for (int k = 0; k < 300; k++) begin
      ch = 1'($urandom_range(0, 1));
      d  = 16'($urandom_range(0, 65535));
      send_frame(ch, d, ~(^{ch, d}), 1'b1);
    end
    idle(4);
    check("t5_parity_strobes", n_pe, 300);
    check("t5_err_saturated", error_count, 8'd255);

    // 6: reset in the middle of data bit 8, then clean frame
    clear_logs();
    c0 = cyc;
    sp.lo = c0 + 3; sp.hi = c0 + LAT;
    busy_q.push_back(sp);
    d = 16'hF0F0;
    drive_bit(1'b0);
    drive_bit(1'b0);
    for (int i = 15; i >= 9; i--) drive_bit(d[i]);
    serial_in = d[8];
    repeat (HALF) @(posedge clk);
    #1;
    reset = 1'b1;
    serial_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("t6_after_reset", {rx_valid, parity_error, frame_error, busy, rx_channel, rx_data, error_count}, 64'd0);
    @(posedge clk); #1;
    idle(100);
    check("t6_no_partial_strobe", got_q.size() + n_pe + n_fe, 0);
    send_frame(1'b0, 16'h0F0F, 1'b0, 1'b1);
    idle(4);
    check("t6_valid_count", got_q.size(), 1);
    if (got_q.size() >= 1) begin
      check("t6_data", got_q[0].data, 16'h0F0F);
      check("t6_channel", got_q[0].ch, 1'b0);
    end
    check("t6_err_count", error_count, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
